// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    // Pointer width for a power-of-two depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Request decoded from {wt_en, rd_en}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_RW   = 2'b11
    } fifo_op_e;

endpackage : sync_fifo_pkg

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port.
// Unreset by design; reading and writing one address in the same edge returns the old word.
module sync_fifo_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : sync_fifo_ram

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, thresholds, overflow/underflow
// pulses and empty-bypass. Define SYNC_FIFO_ASSERT_EN to compile the SVA checks and covers.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2,
    localparam int unsigned CNT_W    = ptr_w(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wt_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] datain,
    output logic [DATA_W-1:0] dataout,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);

    fifo_op_e           op;
    logic [PTR_W-1:0]   wt_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_nxt;
    logic               wr_acc;
    logic               rd_acc;
    logic               byp;
    logic               ovf_nxt;
    logic               udf_nxt;
    logic               sel_byp;
    logic [DATA_W-1:0]  byp_q;
    logic [DATA_W-1:0]  ram_q;

    assign op = fifo_op_e'({wt_en, rd_en});

    // Flags come straight from the count register.
    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == CNT_W'(0));
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    // Request arbitration against the current occupancy.
    always_comb begin
        wr_acc  = 1'b0;
        rd_acc  = 1'b0;
        byp     = 1'b0;
        ovf_nxt = 1'b0;
        udf_nxt = 1'b0;
        unique case (op)
            OP_WR: begin
                if (full) ovf_nxt = 1'b1;
                else      wr_acc  = 1'b1;
            end
            OP_RD: begin
                if (empty) udf_nxt = 1'b1;
                else       rd_acc  = 1'b1;
            end
            OP_RW: begin
                if (empty) begin
                    byp = 1'b1;
                end else begin
                    wr_acc = 1'b1;
                    rd_acc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        count_nxt = count;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wt_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wt_ptr <= wt_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
            count     <= count_nxt;
            overflow  <= ovf_nxt;
            underflow <= udf_nxt;
        end
    end

    // Output source: the bypass register (cleared by reset) or the RAM read register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_byp <= 1'b1;
            byp_q   <= '0;
        end else if (byp) begin
            sel_byp <= 1'b1;
            byp_q   <= datain;
        end else if (rd_acc) begin
            sel_byp <= 1'b0;
        end
    end

    assign dataout = sel_byp ? byp_q : ram_q;

    sync_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wt_ptr),
        .wdata (datain),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

`ifdef SYNC_FIFO_ASSERT_EN
    a_count_max: assert property (@(posedge clk) disable iff (!rst)
        count <= CNT_W'(DEPTH));

    a_full_empty: assert property (@(posedge clk) disable iff (!rst)
        !(full && empty));

    a_ovf_cause: assert property (@(posedge clk) disable iff (!rst)
        overflow |-> $past(wt_en && !rd_en && full));

    a_udf_cause: assert property (@(posedge clk) disable iff (!rst)
        underflow |-> $past(rd_en && !wt_en && empty));

    a_count_step: assert property (@(posedge clk) disable iff (!rst)
        1'b1 |=> (count == $past(count)) ||
                 (count == $past(count) + CNT_W'(1)) ||
                 (count == $past(count) - CNT_W'(1)));

    a_ptr_hold: assert property (@(posedge clk) disable iff (!rst)
        (!wt_en && !rd_en) |=> ($stable(wt_ptr) && $stable(rd_ptr)));

    c_full: cover property (@(posedge clk) disable iff (!rst) full);

    c_bypass: cover property (@(posedge clk) disable iff (!rst) byp);

    c_wrap: cover property (@(posedge clk) disable iff (!rst)
        wr_acc && (wt_ptr == {PTR_W{1'b1}}));
`endif

endmodule : sync_fifo_param

// File: tb/tb_sync_fifo_param.sv
// Directed plus random bench for sync_fifo_param (DEPTH=4, AF=3, AE=1) against a queue model.
module tb_sync_fifo_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEP   = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = $clog2(DEP) + 1;

    logic          clk;
    logic          rst;
    logic          wt_en;
    logic          rd_en;
    logic [DW-1:0] datain;
    logic [DW-1:0] dataout;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          underflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;
    logic          m_udf;

    sync_fifo_param #(
        .DATA_W    (DW),
        .DEPTH     (DEP),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wt_en        (wt_en),
        .rd_en        (rd_en),
        .datain       (datain),
        .dataout      (dataout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ph);
        int sz;
        sz = q.size();
        chk({ph, ".dataout"},      32'(dataout),      32'(m_dout));
        chk({ph, ".count"},        32'(count),        32'(sz));
        chk({ph, ".full"},         32'(full),         32'(sz == DEP));
        chk({ph, ".empty"},        32'(empty),        32'(sz == 0));
        chk({ph, ".almost_full"},  32'(almost_full),  32'(sz >= AF));
        chk({ph, ".almost_empty"}, 32'(almost_empty), 32'(sz <= AE));
        chk({ph, ".overflow"},     32'(overflow),     32'(m_ovf));
        chk({ph, ".underflow"},    32'(underflow),    32'(m_udf));
    endtask

    // One clock of stimulus; the model is advanced from the pre-edge occupancy.
    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input string ph);
        int sz;
        sz     = q.size();
        wt_en  = w;
        rd_en  = r;
        datain = d;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        if (w && r) begin
            if (sz == 0) begin
                m_dout = d;
            end else begin
                m_dout = q.pop_front();
                q.push_back(d);
            end
        end else if (w) begin
            if (sz == DEP) m_ovf = 1'b1;
            else           q.push_back(d);
        end else if (r) begin
            if (sz == 0) m_udf = 1'b1;
            else         m_dout = q.pop_front();
        end
        @(posedge clk);
        #1;
        wt_en = 1'b0;
        rd_en = 1'b0;
        check_all(ph);
    endtask

    initial begin
        rst    = 1'b0;
        wt_en  = 1'b0;
        rd_en  = 1'b0;
        datain = '0;
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b1;

        // Mid-stream reset at count=3 clears everything asynchronously.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'($urandom), "prefill");
        rst = 1'b0;
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_held");
        rst = 1'b1;
        step(1'b1, 1'b0, 8'hA1, "post_rst_wr");
        step(1'b0, 1'b1, 8'h00, "post_rst_rd");

        // Fill, overflow, drain.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'(8'h10 + i), "fill");
        step(1'b1, 1'b0, 8'hEE, "overflow");
        step(1'b0, 1'b0, 8'h00, "ovf_clear");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "drain");

        step(1'b0, 1'b1, 8'h00, "underflow");
        step(1'b0, 1'b0, 8'h00, "udf_clear");

        step(1'b1, 1'b1, 8'h5C, "bypass");
        step(1'b0, 1'b0, 8'h00, "byp_hold");

        // Simultaneous read/write while full.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, DW'($urandom), "fill2");
        step(1'b1, 1'b1, 8'h77, "full_rw");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "full_rw_drain");

        // Alternating traffic wraps the pointers across the thresholds.
        step(1'b1, 1'b0, DW'($urandom), "wrap_pre");
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 1'b0, DW'($urandom), "wrap_wr");
            step(1'b1, 1'b0, DW'($urandom), "wrap_wr2");
            step(1'b0, 1'b1, 8'h00, "wrap_rd");
            step(1'b0, 1'b1, 8'h00, "wrap_rd2");
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_sync_fifo_param
